// File: rtl/controlador_jogo.sv
// Battleship game-flow controller: conditions push-buttons, runs the mode FSM and the fire/result handshake.
// Optional CONTROLADOR_DEBOUNCE_EN inserts a DEB_CICLOS stability filter between synchronizer and edge detector.
`timescale 1ns/1ps
module controlador_jogo #(
    parameter int MAX_COORD    = 4,
    parameter int NUM_MAPAS    = 4,
    parameter int MAX_TIROS    = 15,
    parameter int ALVOS        = 9,
    parameter int RESP_TIMEOUT = 15,
    parameter int DEB_CICLOS   = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       botao_liga,
    input  logic       botao_confirma,
    input  logic       botao_avanca,
    input  logic       botao_campo,
    input  logic       resultado_valido,
    input  logic       acerto,
    output logic       ATAQUE,
    output logic       PREPARACAO,
    output logic       DESLIGADO,
    output logic [2:0] coordColuna,
    output logic [2:0] coordLinha,
    output logic [2:0] mapa,
    output logic       campoSel,
    output logic       disparo,
    output logic       fim,
    output logic       vitoria,
    output logic [3:0] tiros,
    output logic [3:0] acertos
);
    localparam logic [2:0]    COORD_LAST = 3'(MAX_COORD);
    localparam logic [2:0]    MAPA_LAST  = 3'(NUM_MAPAS - 1);
    localparam logic [3:0]    TIROS_LIM  = 4'(MAX_TIROS);
    localparam logic [3:0]    ALVOS_LIM  = 4'(ALVOS);
    localparam int            TW         = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST     = TW'(RESP_TIMEOUT - 1);

    if (MAX_COORD > 7 || NUM_MAPAS < 1 || NUM_MAPAS > 8 || MAX_TIROS > 15 || ALVOS > 15 ||
        RESP_TIMEOUT < 1 || DEB_CICLOS < 1) begin : g_param_check
        $error("controlador_jogo: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_DESLIGADO, S_PREPARACAO, S_ATAQUE, S_AGUARDA, S_FIM
    } estado_t;

    // Button bit order: 0 liga, 1 confirma, 2 avanca, 3 campo
    logic [3:0] btn_raw, sync1, sync2, lvl, lvl_prev, pulso;
    assign btn_raw = {botao_campo, botao_avanca, botao_confirma, botao_liga};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            lvl_prev <= '0;
            pulso    <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            lvl_prev <= lvl;
            pulso    <= lvl & ~lvl_prev;
        end
    end

`ifdef CONTROLADOR_DEBOUNCE_EN
    localparam int            DW       = $clog2(DEB_CICLOS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CICLOS - 1);
    logic [3:0]    deb;
    logic [DW-1:0] deb_cnt [4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end
    assign lvl = deb;
`else
    assign lvl = sync2;
`endif

    logic p_liga, p_conf, p_av, p_campo;
    assign {p_campo, p_av, p_conf, p_liga} = pulso;

    estado_t       estado, estado_nxt;
    logic [2:0]    coluna_nxt, linha_nxt, mapa_nxt;
    logic          campo_nxt, campo_ef, vitoria_nxt, disparo_nxt;
    logic [3:0]    tiros_nxt, acertos_nxt, tiros_inc, acertos_inc, acertos_pos;
    logic [TW-1:0] tempo, tempo_nxt;

    assign tiros_inc   = (tiros == 4'd15) ? 4'd15 : tiros + 4'd1;
    assign acertos_inc = (acertos == 4'd15) ? 4'd15 : acertos + 4'd1;
    assign acertos_pos = (resultado_valido && acerto) ? acertos_inc : acertos;

    function automatic logic [2:0] inc_coord(input logic [2:0] v);
        return (v == COORD_LAST) ? 3'd0 : v + 3'd1;
    endfunction

    always_comb begin
        estado_nxt  = estado;
        coluna_nxt  = coordColuna;
        linha_nxt   = coordLinha;
        mapa_nxt    = mapa;
        campo_nxt   = campoSel;
        tiros_nxt   = tiros;
        acertos_nxt = acertos;
        vitoria_nxt = vitoria;
        disparo_nxt = 1'b0;
        tempo_nxt   = tempo;
        campo_ef    = campoSel ^ p_campo;
        if (p_liga && estado != S_DESLIGADO) begin
            estado_nxt  = S_DESLIGADO;
            coluna_nxt  = '0;
            linha_nxt   = '0;
            mapa_nxt    = '0;
            campo_nxt   = 1'b0;
            tiros_nxt   = '0;
            acertos_nxt = '0;
            vitoria_nxt = 1'b0;
            tempo_nxt   = '0;
        end else begin
            case (estado)
                S_DESLIGADO: if (p_liga) estado_nxt = S_PREPARACAO;
                S_PREPARACAO: begin
                    if (p_conf) begin
                        estado_nxt  = S_ATAQUE;
                        coluna_nxt  = '0;
                        linha_nxt   = '0;
                        campo_nxt   = 1'b0;
                        tiros_nxt   = '0;
                        acertos_nxt = '0;
                    end else if (p_av) begin
                        mapa_nxt = (mapa == MAPA_LAST) ? 3'd0 : mapa + 3'd1;
                    end
                end
                S_ATAQUE: begin
                    if (p_conf) begin
                        estado_nxt  = S_AGUARDA;
                        disparo_nxt = 1'b1;
                        tempo_nxt   = '0;
                    end else begin
                        // avanca acts on the field selected after a same-cycle campo toggle
                        campo_nxt = campo_ef;
                        if (p_av && campo_ef)  linha_nxt  = inc_coord(coordLinha);
                        if (p_av && !campo_ef) coluna_nxt = inc_coord(coordColuna);
                    end
                end
                S_AGUARDA: begin
                    if (resultado_valido || tempo == T_LAST) begin
                        tiros_nxt   = tiros_inc;
                        acertos_nxt = acertos_pos;
                        if (acertos_pos >= ALVOS_LIM) begin
                            estado_nxt  = S_FIM;
                            vitoria_nxt = 1'b1;
                        end else if (tiros_inc >= TIROS_LIM) begin
                            estado_nxt  = S_FIM;
                            vitoria_nxt = 1'b0;
                        end else begin
                            estado_nxt = S_ATAQUE;
                        end
                    end else begin
                        tempo_nxt = tempo + TW'(1);
                    end
                end
                S_FIM: begin
                    if (p_conf) begin
                        estado_nxt  = S_PREPARACAO;
                        tiros_nxt   = '0;
                        acertos_nxt = '0;
                        vitoria_nxt = 1'b0;
                    end
                end
                default: estado_nxt = S_DESLIGADO;
            endcase
        end
    end

    // Mode lines are registered from the next state so they never glitch on decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= S_DESLIGADO;
            coordColuna <= '0;
            coordLinha  <= '0;
            mapa        <= '0;
            campoSel    <= 1'b0;
            tiros       <= '0;
            acertos     <= '0;
            vitoria     <= 1'b0;
            disparo     <= 1'b0;
            tempo       <= '0;
            ATAQUE      <= 1'b0;
            PREPARACAO  <= 1'b0;
            DESLIGADO   <= 1'b1;
            fim         <= 1'b0;
        end else begin
            estado      <= estado_nxt;
            coordColuna <= coluna_nxt;
            coordLinha  <= linha_nxt;
            mapa        <= mapa_nxt;
            campoSel    <= campo_nxt;
            tiros       <= tiros_nxt;
            acertos     <= acertos_nxt;
            vitoria     <= vitoria_nxt;
            disparo     <= disparo_nxt;
            tempo       <= tempo_nxt;
            ATAQUE      <= (estado_nxt == S_ATAQUE) || (estado_nxt == S_AGUARDA);
            PREPARACAO  <= (estado_nxt == S_PREPARACAO);
            DESLIGADO   <= (estado_nxt == S_DESLIGADO);
            fim         <= (estado_nxt == S_FIM);
        end
    end
endmodule

// File: tb/tb_controlador_jogo.sv
// Bench for controlador_jogo: stimulus updates a game-level model and queues expected output snapshots
// with their arrival cycle; a monitor pops one entry on every observed output change.
`timescale 1ns/1ps
module tb_controlador_jogo;
    localparam int MAX_COORD = 4, NUM_MAPAS = 4, MAX_TIROS = 3, ALVOS = 2;
    localparam int RESP_TIMEOUT = 15, DEB_CICLOS = 4;
`ifdef CONTROLADOR_DEBOUNCE_EN
    localparam int EXTRA = DEB_CICLOS;
`else
    localparam int EXTRA = 0;
`endif
    localparam int M_OFF = 0, M_PREP = 1, M_ATK = 2, M_WAIT = 3, M_FIM = 4;
    localparam int B_LIGA = 0, B_CONF = 1, B_AV = 2, B_CAMPO = 3;

    logic clock = 1'b0, reset_n = 1'b0;
    logic [3:0] btn = '0;
    logic resultado_valido = 1'b0, acerto = 1'b0;
    logic ATAQUE, PREPARACAO, DESLIGADO, campoSel, disparo, fim, vitoria;
    logic [2:0] coordColuna, coordLinha, mapa;
    logic [3:0] tiros, acertos;

    controlador_jogo #(.MAX_COORD(MAX_COORD), .NUM_MAPAS(NUM_MAPAS), .MAX_TIROS(MAX_TIROS),
                       .ALVOS(ALVOS), .RESP_TIMEOUT(RESP_TIMEOUT), .DEB_CICLOS(DEB_CICLOS)) dut (
        .clock(clock), .reset_n(reset_n),
        .botao_liga(btn[0]), .botao_confirma(btn[1]), .botao_avanca(btn[2]), .botao_campo(btn[3]),
        .resultado_valido(resultado_valido), .acerto(acerto),
        .ATAQUE(ATAQUE), .PREPARACAO(PREPARACAO), .DESLIGADO(DESLIGADO),
        .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa), .campoSel(campoSel),
        .disparo(disparo), .fim(fim), .vitoria(vitoria), .tiros(tiros), .acertos(acertos)
    );

    typedef struct packed {
        logic       atq, prep, desl;
        logic [2:0] col, lin, mapa;
        logic       campo, disp, fim, vit;
        logic [3:0] tiros, acertos;
    } obs_t;
    typedef struct packed {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0, miscompares = 0;
    bit   mon_en = 1'b0;
    obs_t last_exp, prev_obs;
    int   m_mode, m_col, m_lin, m_map, m_campo, m_tiros, m_acertos, m_vit, m_entry;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.atq = ATAQUE; o.prep = PREPARACAO; o.desl = DESLIGADO;
        o.col = coordColuna; o.lin = coordLinha; o.mapa = mapa; o.campo = campoSel;
        o.disp = disparo; o.fim = fim; o.vit = vitoria; o.tiros = tiros; o.acertos = acertos;
        return o;
    endfunction

    function automatic obs_t model_obs(input bit disp);
        obs_t o;
        o.atq  = (m_mode == M_ATK) || (m_mode == M_WAIT);
        o.prep = (m_mode == M_PREP);
        o.desl = (m_mode == M_OFF);
        o.col  = 3'(m_col); o.lin = 3'(m_lin); o.mapa = 3'(m_map); o.campo = 1'(m_campo);
        o.disp = disp; o.fim = (m_mode == M_FIM); o.vit = 1'(m_vit);
        o.tiros = 4'(m_tiros); o.acertos = 4'(m_acertos);
        return o;
    endfunction

    // Several model events landing on the same edge merge into one expected snapshot.
    function automatic void push_exp(input int c, input bit disp);
        exp_t e;
        obs_t o;
        o = model_obs(disp);
        if (sb.size() > 0 && sb[sb.size()-1].cyc == c) begin
            e = sb.pop_back(); e.o = o; sb.push_back(e); last_exp = o;
        end else if (o != last_exp) begin
            e.cyc = c; e.o = o; sb.push_back(e); last_exp = o;
        end
    endfunction

    function automatic void model_clear();
        m_mode = M_OFF; m_col = 0; m_lin = 0; m_map = 0; m_campo = 0;
        m_tiros = 0; m_acertos = 0; m_vit = 0;
    endfunction

    function automatic void model_press(input int b, input int eff);
        if (b == B_LIGA) begin
            if (m_mode == M_OFF) m_mode = M_PREP;
            else model_clear();
            push_exp(eff, 1'b0);
            return;
        end
        case (m_mode)
            M_PREP: begin
                if (b == B_CONF) begin
                    m_mode = M_ATK; m_col = 0; m_lin = 0; m_campo = 0; m_tiros = 0; m_acertos = 0;
                    push_exp(eff, 1'b0);
                end else if (b == B_AV) begin
                    m_map = (m_map + 1) % NUM_MAPAS;
                    push_exp(eff, 1'b0);
                end
            end
            M_ATK: begin
                if (b == B_CONF) begin
                    m_mode = M_WAIT; m_entry = eff;
                    push_exp(eff, 1'b1);
                    push_exp(eff + 1, 1'b0);
                end else if (b == B_CAMPO) begin
                    m_campo = 1 - m_campo;
                    push_exp(eff, 1'b0);
                end else begin
                    if (m_campo == 1) m_lin = (m_lin + 1) % (MAX_COORD + 1);
                    else              m_col = (m_col + 1) % (MAX_COORD + 1);
                    push_exp(eff, 1'b0);
                end
            end
            M_FIM: begin
                if (b == B_CONF) begin
                    m_mode = M_PREP; m_tiros = 0; m_acertos = 0; m_vit = 0;
                    push_exp(eff, 1'b0);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void model_score(input bit hit, input int eff);
        m_tiros = (m_tiros < 15) ? m_tiros + 1 : 15;
        if (hit) m_acertos = (m_acertos < 15) ? m_acertos + 1 : 15;
        if (m_acertos >= ALVOS)        begin m_mode = M_FIM; m_vit = 1; end
        else if (m_tiros >= MAX_TIROS) begin m_mode = M_FIM; m_vit = 0; end
        else m_mode = M_ATK;
        push_exp(eff, 1'b0);
    endfunction

    always @(negedge clock) begin
        obs_t o;
        exp_t e;
        if (mon_en) begin
            o = dut_obs();
            if (o != prev_obs) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_change at cycle %0d: got %0h, expected unchanged %0h", cyc, o, prev_obs);
                end else begin
                    e = sb.pop_front();
                    check("change_cycle", 64'(cyc), 64'(e.cyc));
                    check("outputs", 64'(o), 64'(e.o));
                end
                prev_obs = o;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic press_mask(input logic [3:0] m, input int hold);
        int eff;
        @(negedge clock);
        eff = cyc + 4 + EXTRA;
        btn = btn | m;
        if (m[B_LIGA])  model_press(B_LIGA, eff);
        if (m[B_CONF])  model_press(B_CONF, eff);
        if (m[B_CAMPO]) model_press(B_CAMPO, eff);
        if (m[B_AV])    model_press(B_AV, eff);
        repeat (hold) @(negedge clock);
        btn = '0;
        repeat (4 + 2 * EXTRA) @(negedge clock);
    endtask

    task automatic press(input int b);
        press_mask(4'(1 << b), 1 + EXTRA + $urandom_range(0, 2));
    endtask

    task automatic result_now(input bit hit);
        resultado_valido = 1'b1; acerto = hit;
        model_score(hit, cyc + 1);
        @(negedge clock);
        resultado_valido = 1'b0; acerto = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clock);
        acerto = 1'b0;
    endtask

    task automatic timeout_wait();
        model_score(1'b0, m_entry + RESP_TIMEOUT);
        wait_until(m_entry + RESP_TIMEOUT + 2);
    endtask

    task automatic ignored_press_if_room(input int b);
        if (cyc + 6 + 3 * EXTRA + 3 < m_entry + RESP_TIMEOUT) press_mask(4'(1 << b), 1 + EXTRA);
    endtask

    task automatic liga_with_result();
        int k;
        @(negedge clock);
        k = cyc;
        btn[B_LIGA] = 1'b1;
        model_press(B_LIGA, k + 4 + EXTRA);
        repeat (1 + EXTRA) @(negedge clock);
        btn[B_LIGA] = 1'b0;
        wait_until(k + 3 + EXTRA);
        resultado_valido = 1'b1; acerto = 1'b1;
        @(negedge clock);
        resultado_valido = 1'b0; acerto = 1'b0;
        repeat (4 + 2 * EXTRA) @(negedge clock);
    endtask

    task automatic glitch_avanca();
        int k;
        @(negedge clock);
        k = cyc;
        btn[B_AV] = 1'b1;
`ifndef CONTROLADOR_DEBOUNCE_EN
        model_press(B_AV, k + 4);
`endif
        @(negedge clock);
        btn[B_AV] = 1'b0;
        repeat (6 + 2 * EXTRA) @(negedge clock);
    endtask

    task automatic handle_wait();
        int r, t, deadline;
        deadline = m_entry + RESP_TIMEOUT;
        r = $urandom_range(0, 9);
        if (r < 3) ignored_press_if_room(B_CONF + r);
        r = $urandom_range(0, 9);
        if (r < 6 && cyc + 2 < deadline) begin
            t = cyc + $urandom_range(0, deadline - cyc - 2);
            wait_until(t);
            result_now(1'($urandom_range(0, 1)));
        end else if (r < 8 || cyc + 5 + EXTRA >= deadline) begin
            timeout_wait();
        end else begin
            liga_with_result();
        end
    endtask

    initial begin
        obs_t rst_o;
        int r;
        model_clear();
        rst_o = model_obs(1'b0);
        repeat (3) @(negedge clock);
        check("reset_outputs_held", 64'(dut_obs()), 64'(rst_o));
        reset_n = 1'b1;
        last_exp = rst_o; prev_obs = rst_o; mon_en = 1'b1;
        @(negedge clock);
        check("reset_outputs", 64'(dut_obs()), 64'(rst_o));

        press(B_LIGA);
        check("power_on_prep", 64'(PREPARACAO), 64'd1);
        repeat (5) press(B_AV);
        check("mapa_wrap", 64'(mapa), 64'd1);
        press(B_CONF);
        repeat (6) press(B_AV);
        check("coluna_wrap", 64'(coordColuna), 64'd1);
        press(B_CAMPO);
        repeat (2) press(B_AV);
        check("linha_edit", 64'(coordLinha), 64'd2);

        press(B_CONF);
        result_now(1'b1);
        check("tiros_after_hit", 64'(tiros), 64'd1);
        check("acertos_after_hit", 64'(acertos), 64'd1);
        press(B_CONF);
        ignored_press_if_room(B_CONF);
        timeout_wait();
        check("tiros_after_timeout", 64'(tiros), 64'd2);
        check("acertos_after_timeout", 64'(acertos), 64'd1);
        press(B_CONF);
        result_now(1'b1);
        check("final_shot_hit_wins", 64'({fim, vitoria, tiros}), 64'({2'b11, 4'd3}));
        press(B_CONF);
        check("restart_clears", 64'({PREPARACAO, tiros, acertos, mapa}), 64'({1'b1, 8'd0, 3'd1}));

        press(B_CONF);
        press(B_CONF); result_now(1'b0);
        press(B_CONF); result_now(1'b0);
        press(B_CONF); timeout_wait();
        check("loss", 64'({fim, vitoria}), 64'(2'b10));
        press(B_CONF);
        press(B_CONF);
        press(B_CONF); result_now(1'b1);
        press(B_CONF); result_now(1'b1);
        check("two_hits_win", 64'({fim, vitoria, tiros}), 64'({2'b11, 4'd2}));
        press(B_CONF);
        glitch_avanca();
        press(B_CONF);
        press(B_CONF);
        if (cyc + 5 + EXTRA < m_entry + RESP_TIMEOUT) liga_with_result();
        else begin timeout_wait(); press(B_LIGA); end
        check("liga_overrides_result", 64'({DESLIGADO, tiros}), 64'({1'b1, 4'd0}));

        for (int i = 0; i < 70; i++) begin
            r = $urandom_range(0, 99);
            case (m_mode)
                M_OFF:  press(r < 60 ? B_LIGA : 1 + r % 3);
                M_PREP: begin
                    if (r < 5)       press(B_LIGA);
                    else if (r < 25) press(B_CONF);
                    else if (r < 35) press(B_CAMPO);
                    else             press(B_AV);
                end
                M_ATK: begin
                    if (r < 3)       press(B_LIGA);
                    else if (r < 30) press(B_CONF);
                    else if (r < 45) press(B_CAMPO);
                    else if (r < 55) press_mask(4'b1100, 1 + EXTRA);
                    else             press(B_AV);
                    if (m_mode == M_WAIT) handle_wait();
                end
                M_FIM: begin
                    if (r < 50)      press(B_CONF);
                    else if (r < 60) press(B_LIGA);
                    else             press(B_AV);
                end
                default: handle_wait();
            endcase
        end

        for (int i = 0; i < 8 && m_mode != M_ATK; i++) begin
            if (m_mode == M_WAIT) handle_wait();
            else press(m_mode == M_OFF ? B_LIGA : B_CONF);
        end
        press(B_CONF);
        @(negedge clock);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("async_reset_mid_wait", 64'(dut_obs()), 64'(rst_o));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_after_reset", 64'(dut_obs()), 64'(rst_o));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end
endmodule
